idct_dp_sched: RTL and testbench
================================

# idct_dp_sched

Issue scheduler for the 4-tap IDCT dot-product datapath (the skewed multiply/add chain with a 2048 round / 12-bit arithmetic shift at its output). It accepts one 4-coefficient vector per handshake and staggers the coefficients across four lanes, one cycle apart, to match the datapath's adder chain. It tracks every vector in flight, captures the aligned result into an output FIFO, and only issues when FIFO space is guaranteed, because the datapath has no stall. It also enforces block boundaries with `in_last`/`out_last`.

## Interface
- `FIFO_DEPTH`, 8: output FIFO entries; power of two, ≥ 2.
- `DP_LAT`, 4: cycles from a value on `dp_x1` to the matching registered `dp_result`.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  input vector valid.
- `in_ready`  out  1  scheduler can accept the vector this cycle.
- `in_x0..in_x3`  in  25 each  signed coefficients for taps 1..4.
- `in_last`  in  1  vector is the last one of a block.
- `dp_x1..dp_x4`  out  25 each  lane drives into the datapath `d_in_1..d_in_4`.
- `dp_result`  in  25  datapath `d_out`, signed.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  downstream accepts the head.
- `out_data`  out  25  signed result at the FIFO head.
- `out_last`  out  1  head is the last result of a block.
- `busy`  out  1  state is not IDLE, or the FIFO is non-empty.

## Operation
- **Accept.** A vector is accepted when `in_valid & in_ready` at a rising edge (cycle t).
- **Lane skew.** The accepted vector drives the lanes in a staggered pattern:
  - `in_x0` → `dp_x1` during t+1.
  - `in_x1` → `dp_x2` during t+2.
  - `in_x2` → `dp_x3` during t+3.
  - `in_x3` → `dp_x4` during t+4.
  - Skew registers are 25-bit signed, with no arithmetic applied.
  - A lane with no scheduled value drives 0.
- **Token pipe.** A shift register of depth DP_LAT+1 carries {valid, last} per vector.
  - When its tail is valid, `dp_result` is written into the FIFO, together with last, at the end of cycle t+1+DP_LAT (t+5 by default).
- **Credits.**
  - inflight = number of valid tokens in the pipe.
  - `in_ready` = (state==RUN or IDLE) & (fifo_count + inflight < FIFO_DEPTH).
  - A pop in the same cycle does not add credit until the next cycle (registered count).
  - The FIFO can therefore never overflow. An overflow attempt is a design error, and the bench asserts it never happens.
- **FIFO output.**
  - `out_data` and `out_last` are the FIFO head, read combinationally.
  - A pop occurs on `out_valid & out_ready`.
  - A simultaneous push and pop leaves the count unchanged.
  - The read and write pointers wrap modulo FIFO_DEPTH.
- **State machine.**
  - IDLE → RUN on the first accept.
  - RUN → DRAIN on an accept with `in_last`=1.
  - DRAIN: `in_ready`=0. Go to IDLE when the token with last has been written into the FIFO.
  - RUN → IDLE when the pipe is empty and no accept occurs for one cycle; back-to-back accepts stay in RUN.
- **Reset.** Asserting `reset` (low) at any time behaves as follows:
  - The state goes to IDLE.
  - The token pipe, skew registers and FIFO are cleared, and in-flight vectors are discarded.
  - The datapath's own registers are reset by the parent.

## Timing
- **Reset values:**
  - `in_ready`=1, `dp_x1..4`=0, `out_valid`=0, `out_data`=0, `out_last`=0, `busy`=0.
- **Throughput:** one vector per cycle while credits remain.
- **Latency:** an accept at cycle t gives `out_valid` at t+6 with default parameters (DP_LAT+2) into an empty FIFO.
- **In DRAIN:** `in_ready` stays low, including the cycle in which IDLE is entered. The next block's first accept is therefore possible at the earliest one cycle after `out_last` is pushed into the FIFO.
- **Full FIFO with `out_ready`=0:** `in_ready` falls once fifo_count+inflight reaches FIFO_DEPTH. It rises the cycle after the first pop.

## Test plan
- **Single vector.** Accept x=(4096,4096,4096,4096) at t0 with a datapath model of coefficients 64,36,-64,-83. Required:
  - `dp_x1..4` = 4096 on t0+1..t0+4.
  - `out_data`=(4096·(64+36−64−83)+2048)>>>12 = −47 at t0+6.
- **Back-to-back.** Stream 8 vectors with `out_ready`=1. Required: 8 results in order, one per cycle from t0+6 to t0+13, and `in_ready` never drops.
- **Backpressure.** Hold `out_ready`=0 and offer 12 vectors. Required:
  - Exactly 8 are accepted, then `in_ready`=0, with no overflow.
  - Releasing `out_ready` yields all 8 results in order, after which accepts resume.
- **Block boundary.** Send 3 vectors with `in_last` on the third. Required:
  - `in_ready`=0 from the cycle after the third accept until `out_last` is written.
  - `out_last`=1 only on the third result.
- **Reset mid-stream.** Pull `reset` low while 3 vectors are in flight. Required:
  - All outputs return to their reset values immediately.
  - No stale results appear after `reset` is released.
- **Negative rounding.** Use x0=-1 and all other taps 0. Required: `out_data` = (−64+2048)>>>12 = 0. With x0=−100: (−6400+2048)>>>12 = −2.

Source files
------------

// File: rtl/idct_dp_sched_if.sv
// Bus bundle for the IDCT dot-product issue scheduler: input vector stream,
// skewed datapath lanes with the returning result, and the output result stream.
interface idct_dp_sched_if;
    logic               in_valid;
    logic               in_ready;
    logic signed [24:0] in_x0;
    logic signed [24:0] in_x1;
    logic signed [24:0] in_x2;
    logic signed [24:0] in_x3;
    logic               in_last;

    logic signed [24:0] dp_x1;
    logic signed [24:0] dp_x2;
    logic signed [24:0] dp_x3;
    logic signed [24:0] dp_x4;
    logic signed [24:0] dp_result;

    logic               out_valid;
    logic               out_ready;
    logic signed [24:0] out_data;
    logic               out_last;

    // Scheduler side.
    modport slave (
        input  in_valid, in_x0, in_x1, in_x2, in_x3, in_last,
        input  dp_result, out_ready,
        output in_ready, dp_x1, dp_x2, dp_x3, dp_x4,
        output out_valid, out_data, out_last
    );

    // Environment side: vector source, datapath and result sink.
    modport master (
        output in_valid, in_x0, in_x1, in_x2, in_x3, in_last,
        output dp_result, out_ready,
        input  in_ready, dp_x1, dp_x2, dp_x3, dp_x4,
        input  out_valid, out_data, out_last
    );
endinterface

// File: rtl/idct_dp_sched.sv
// Issue scheduler for the 4-tap IDCT dot-product datapath. Staggers each
// accepted coefficient vector across four lanes, tracks vectors in flight with
// a token pipe, and captures aligned results into an output FIFO. Issue is
// credit-gated so the stall-free datapath can never overrun the FIFO.
module idct_dp_sched #(
    parameter int FIFO_DEPTH = 8,
    parameter int DP_LAT     = 4
) (
    input  logic              clk,
    input  logic              reset,
    idct_dp_sched_if.slave    bus,
    output logic              busy
);
    localparam int PIPE_D = DP_LAT + 1;
    localparam int TAIL   = PIPE_D - 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + PIPE_D + 1) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t             state;
    logic [PIPE_D-1:0]  tok_valid;
    logic [PIPE_D-1:0]  tok_last;
    logic signed [24:0] lane1_q;
    logic signed [24:0] lane2_q [2];
    logic signed [24:0] lane3_q [3];
    logic signed [24:0] lane4_q [4];
    logic signed [24:0] fifo_data [FIFO_DEPTH];
    logic               fifo_last [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   fifo_count;
    logic [CNT_W-1:0]   inflight;
    logic               accept;
    logic               push;
    logic               pop;

    // Count valid tokens in the pipe: vectors issued but not yet in the FIFO.
    always_comb begin
        // NOTE: assign a default before the loop so no path leaves the variable unassigned (no latch).
        inflight = '0;
        for (int i = 0; i < PIPE_D; i++) begin
            inflight = inflight + CNT_W'(tok_valid[i]);
        end
    end

    // Credit check uses the registered FIFO count, so a pop frees space one cycle later.
    assign bus.in_ready = (state != DRAIN) && ((fifo_count + inflight) < CNT_W'(FIFO_DEPTH));
    assign accept       = bus.in_valid && bus.in_ready;
    assign push         = tok_valid[TAIL];
    assign pop          = bus.out_valid && bus.out_ready;

    assign bus.dp_x1 = lane1_q;
    assign bus.dp_x2 = lane2_q[1];
    assign bus.dp_x3 = lane3_q[2];
    assign bus.dp_x4 = lane4_q[3];

    assign bus.out_valid = (fifo_count != '0);
    assign bus.out_data  = bus.out_valid ? fifo_data[rd_ptr] : '0;
    assign bus.out_last  = bus.out_valid ? fifo_last[rd_ptr] : 1'b0;
    assign busy          = (state != IDLE) || (fifo_count != '0);

    // Block-level state: RUN while streaming, DRAIN after an in_last accept.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset) begin
            state <= IDLE;
        end else begin
            case (state)
                // A one-vector block (in_last on the first accept) drains straight away.
                IDLE:    if (accept) state <= bus.in_last ? DRAIN : RUN;
                RUN: begin
                    if (accept && bus.in_last)        state <= DRAIN;
                    else if (!accept && inflight == '0) state <= IDLE;
                end
                DRAIN:   if (push && tok_last[TAIL]) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Token pipe and lane skew registers; idle lanes shift in zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tok_valid <= '0;
            tok_last  <= '0;
            lane1_q   <= '0;
            for (int i = 0; i < 2; i++) lane2_q[i] <= '0;
            for (int i = 0; i < 3; i++) lane3_q[i] <= '0;
            for (int i = 0; i < 4; i++) lane4_q[i] <= '0;
        end else begin
            tok_valid  <= {tok_valid[PIPE_D-2:0], accept};
            tok_last   <= {tok_last[PIPE_D-2:0], accept && bus.in_last};
            lane1_q    <= accept ? bus.in_x0 : '0;
            lane2_q[0] <= accept ? bus.in_x1 : '0;
            lane3_q[0] <= accept ? bus.in_x2 : '0;
            lane4_q[0] <= accept ? bus.in_x3 : '0;
            lane2_q[1] <= lane2_q[0];
            for (int i = 1; i < 3; i++) lane3_q[i] <= lane3_q[i-1];
            for (int i = 1; i < 4; i++) lane4_q[i] <= lane4_q[i-1];
        end
    end

    // FIFO pointers and occupancy; push and pop in one cycle cancel out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // FIFO storage: capture the aligned datapath result with its block-end flag.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; pointers/count are, and the head is gated by out_valid.
        if (push) begin
            fifo_data[wr_ptr] <= bus.dp_result;
            fifo_last[wr_ptr] <= tok_last[TAIL];
        end
    end
endmodule

// File: tb/tb_idct_dp_sched.sv
// Self-checking bench for idct_dp_sched: a datapath model closes the loop,
// and a queue-based reference predicts every result from plain arithmetic.
module tb_idct_dp_sched;
    localparam int FIFO_DEPTH = 8;
    localparam int DP_LAT     = 4;

    logic clk = 1'b0;
    logic reset;
    logic busy;

    idct_dp_sched_if bus();

    idct_dp_sched #(.FIFO_DEPTH(FIFO_DEPTH), .DP_LAT(DP_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic signed [24:0] data;
        logic               last;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   pops   = 0;

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Expected result of one vector: dot product with the IDCT row, rounded, >>> 12.
    function automatic logic signed [24:0] ref_dot(input logic signed [24:0] x0, x1, x2, x3);
        longint s;
        s = 64 * longint'(x0) + 36 * longint'(x1) - 64 * longint'(x2) - 83 * longint'(x3);
        return 25'((s + 2048) >>> 12);
    endfunction

    // Datapath model: skewed multiply/add chain, DP_LAT registers from d_in_1 to d_out.
    localparam logic signed [47:0] C1 = 48'sd64;
    localparam logic signed [47:0] C2 = 48'sd36;
    localparam logic signed [47:0] C3 = -48'sd64;
    localparam logic signed [47:0] C4 = -48'sd83;
    logic signed [47:0] acc1, acc2, acc3;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc1          <= '0;
            acc2          <= '0;
            acc3          <= '0;
            bus.dp_result <= '0;
        end else begin
            acc1          <= bus.dp_x1 * C1;
            acc2          <= acc1 + bus.dp_x2 * C2;
            acc3          <= acc2 + bus.dp_x3 * C3;
            bus.dp_result <= 25'((acc3 + bus.dp_x4 * C4 + 48'sd2048) >>> 12);
        end
    end

    // Scoreboard: record accepts, compare every pop against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            sb.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                check("pop_has_entry", (sb.size() > 0) ? 1 : 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    pops++;
                    check("out_data", bus.out_data, e.data);
                    check("out_last", bus.out_last, e.last);
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                check("credit", (sb.size() + (bus.out_valid && bus.out_ready ? 1 : 0) < FIFO_DEPTH) ? 1 : 0, 1);
                e.data = ref_dot(bus.in_x0, bus.in_x1, bus.in_x2, bus.in_x3);
                e.last = bus.in_last;
                sb.push_back(e);
            end
        end
    end

    task automatic drive_vec(input logic signed [24:0] a, b, c, d, input logic last);
        bus.in_x0    = a;
        bus.in_x1    = b;
        bus.in_x2    = c;
        bus.in_x3    = d;
        bus.in_last  = last;
        bus.in_valid = 1'b1;
    endtask

    task automatic rand_vec(input logic last);
        drive_vec(25'($urandom), 25'($urandom), 25'($urandom), 25'($urandom), last);
    endtask

    // Advance to the drive point of the next cycle.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Let everything outstanding drain out; ends at a drive point.
    task automatic wait_empty();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !bus.out_valid) break;
        end
        check("drain_empty", sb.size(), 0);
        next_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int accepted;
        int pops0;
        logic acc;

        reset = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        drive_vec('0, '0, '0, '0, 1'b0);
        bus.in_valid = 1'b0;

        // Reset values.
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_dp_x1", bus.dp_x1, 0);
        check("rst_dp_x4", bus.dp_x4, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_busy", busy, 0);
        next_cycle();
        reset = 1'b1;
        next_cycle();

        // Single vector: lane skew and latency.
        drive_vec(25'sd4096, 25'sd4096, 25'sd4096, 25'sd4096, 1'b0);
        @(negedge clk);
        check("t1_ready", bus.in_ready, 1);
        next_cycle();
        bus.in_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check("t1_dp_x1", bus.dp_x1, (k == 1) ? 4096 : 0);
            check("t1_dp_x2", bus.dp_x2, (k == 2) ? 4096 : 0);
            check("t1_dp_x3", bus.dp_x3, (k == 3) ? 4096 : 0);
            check("t1_dp_x4", bus.dp_x4, (k == 4) ? 4096 : 0);
            check("t1_out_valid", bus.out_valid, (k == 6) ? 1 : 0);
            if (k == 6) begin
                check("t1_out_data", bus.out_data, -47);
                check("t1_busy", busy, 1);
            end
            next_cycle();
        end
        wait_empty();

        // Back-to-back: 8 vectors, results on consecutive cycles 6..13.
        bus.out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (k < 8) rand_vec(1'b0);
            else bus.in_valid = 1'b0;
            @(negedge clk);
            if (k < 8) check("b2b_in_ready", bus.in_ready, 1);
            check("b2b_out_valid", bus.out_valid, (k >= 6 && k <= 13) ? 1 : 0);
            next_cycle();
        end
        wait_empty();

        // Backpressure: offer 12 with out_ready low; exactly 8 fit.
        bus.out_ready = 1'b0;
        accepted = 0;
        rand_vec(1'b0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            if (acc) accepted++;
            next_cycle();
            if (acc) begin
                if (accepted < 12) rand_vec(1'b0);
                else bus.in_valid = 1'b0;
            end
        end
        @(negedge clk);
        check("bp_accepted", accepted, 8);
        check("bp_in_ready_low", bus.in_ready, 0);
        next_cycle();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        pops0 = pops;
        @(negedge clk);
        check("bp_ready_first_pop", bus.in_ready, 0);
        next_cycle();
        @(negedge clk);
        check("bp_ready_after_pop", bus.in_ready, 1);
        next_cycle();
        wait_empty();
        check("bp_pop_count", pops - pops0, 8);
        rand_vec(1'b0);
        @(negedge clk);
        check("bp_resume_ready", bus.in_ready, 1);
        next_cycle();
        wait_empty();

        // Block boundary: last on the third vector, then a next-block vector waits.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_vec(i == 2);
            @(negedge clk);
            check("blk_ready", bus.in_ready, 1);
            next_cycle();
        end
        rand_vec(1'b0);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check("blk_drain_ready", bus.in_ready, (k == 6) ? 1 : 0);
            if (k == 6) begin
                check("blk_out_valid", bus.out_valid, 1);
                check("blk_out_last", bus.out_last, 1);
            end
            next_cycle();
        end
        wait_empty();

        // Reset mid-stream with three vectors in flight.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_vec(25'sd1000 + 25'(i), 25'sd7, 25'sd9, 25'sd11, 1'b0);
            next_cycle();
        end
        bus.in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("mid_rst_in_ready", bus.in_ready, 1);
        check("mid_rst_dp_x1", bus.dp_x1, 0);
        check("mid_rst_dp_x2", bus.dp_x2, 0);
        check("mid_rst_dp_x3", bus.dp_x3, 0);
        check("mid_rst_dp_x4", bus.dp_x4, 0);
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_out_data", bus.out_data, 0);
        check("mid_rst_out_last", bus.out_last, 0);
        check("mid_rst_busy", busy, 0);
        @(posedge clk);
        next_cycle();
        reset = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check("no_stale_valid", bus.out_valid, 0);
            next_cycle();
        end

        // Negative rounding.
        bus.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k == 0) drive_vec(-25'sd1, '0, '0, '0, 1'b0);
            else if (k == 1) drive_vec(-25'sd100, '0, '0, '0, 1'b0);
            else bus.in_valid = 1'b0;
            @(negedge clk);
            if (k == 6) check("neg_m1", bus.out_data, 0);
            if (k == 7) check("neg_m100", bus.out_data, -2);
            if (k >= 6) check("neg_valid", bus.out_valid, 1);
            next_cycle();
        end
        wait_empty();

        // Randomized traffic with blocks and backpressure.
        bus.in_valid = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            next_cycle();
            if (acc || !bus.in_valid) begin
                rand_vec(($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);
                bus.in_valid = ($urandom_range(0, 3) != 0);
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        wait_empty();
        @(negedge clk);
        check("end_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
